// File: rtl/pace_pkg.sv
// Shared pacing definitions: scheduler state encoding, output channel codes,
// and default timing constants (100 MHz clock) also used by the pacemaker
// timing FSM.
package pace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        PULSE,
        RECHARGE,
        BLANK
    } pace_state_t;

    localparam logic [1:0] CH_A  = 2'd0;
    localparam logic [1:0] CH_RV = 2'd1;
    localparam logic [1:0] CH_LV = 2'd2;

    localparam int unsigned DEF_PULSE_WIDTH    = 100_000;   // 1 ms
    localparam int unsigned DEF_RECHARGE_WIDTH = 300_000;   // 3 ms
    localparam int unsigned DEF_BLANK_WIDTH    = 2_500_000; // 25 ms
    localparam int unsigned DEF_CHARGE_TIMEOUT = 1_000_000; // 10 ms

    // Channel code to bit position in the {lv, rv, a} request vectors.
    function automatic logic [2:0] chan_onehot(input logic [1:0] ch);
        chan_onehot = 3'b001 << ch;
    endfunction

endpackage

// File: rtl/pace_prio_sel.sv
// Fixed-priority picker for pending pace requests, RV > LV > A.
// Ports:
//   pending  in  3  latched requests {lv, rv, a}
//   valid    out 1  at least one request pending
//   chan     out 2  winning channel code (CH_A when nothing is pending)
module pace_prio_sel
    import pace_pkg::*;
(
    input  logic [2:0] pending,
    output logic       valid,
    output logic [1:0] chan
);

    always_comb begin
        valid = |pending;
        chan  = CH_A;
        if (pending[1]) begin
            chan = CH_RV;
        end else if (pending[2]) begin
            chan = CH_LV;
        end
    end

endmodule

// File: rtl/pace_output_scheduler.sv
// Shares the single pacing output stage between the atrial, right-ventricle
// and left-ventricle requesters. Each granted request runs CHARGE (wait for
// charge_ready, bounded by a timeout), PULSE, RECHARGE and BLANK, then
// returns to IDLE for one cycle before the next grant.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_a/req_rv/req_lv  in  pace requests (pulse or level)
//   charge_ready         in  output capacitor charged
//   pace_en              out output switch enable (PULSE)
//   recharge_en          out active recharge switch enable (RECHARGE)
//   pace_sel             out routed channel, 0=A 1=RV 2=LV
//   blank                out sense blanking (PULSE, RECHARGE, BLANK)
//   busy                 out not IDLE
//   pending              out latched requests {lv, rv, a}
//   done                 out one-cycle completion strobe per channel
//   overrun              out one-cycle strobe, request hit channel in service
//   charge_fault         out one-cycle strobe, charge timeout
//   fault_sticky         out any charge timeout since reset
module pace_output_scheduler
    import pace_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned PULSE_WIDTH    = DEF_PULSE_WIDTH,
    parameter int unsigned RECHARGE_WIDTH = DEF_RECHARGE_WIDTH,
    parameter int unsigned BLANK_WIDTH    = DEF_BLANK_WIDTH,
    parameter int unsigned CHARGE_TIMEOUT = DEF_CHARGE_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_rv,
    input  logic       req_lv,
    input  logic       charge_ready,
    output logic       pace_en,
    output logic       recharge_en,
    output logic [1:0] pace_sel,
    output logic       blank,
    output logic       busy,
    output logic [2:0] pending,
    output logic [2:0] done,
    output logic       overrun,
    output logic       charge_fault,
    output logic       fault_sticky
);

    localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] RW_LAST = CNT_W'(RECHARGE_WIDTH - 1);
    localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(BLANK_WIDTH - 1);
    localparam logic [CNT_W-1:0] CT_LAST = CNT_W'(CHARGE_TIMEOUT - 1);

    pace_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       sel_q;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       done_q;
    logic             overrun_q, fault_q, sticky_q;

    logic       win_valid;
    logic [1:0] win_chan;
    logic       grant, timeout, finish;
    logic [2:0] req_vec, svc_mask;

    pace_prio_sel u_prio (
        .pending (pending_q),
        .valid   (win_valid),
        .chan    (win_chan)
    );

    assign req_vec  = {req_lv, req_rv, req_a};
    // Channel currently owning the output stage; its new requests are dropped.
    assign svc_mask = (state_q != IDLE) ? chan_onehot(sel_q) : 3'b000;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        timeout = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = CHARGE;
                    grant   = 1'b1;
                end
            end
            CHARGE: begin
                if (charge_ready) begin
                    state_d = PULSE;
                end else if (cnt_q == CT_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
            end
            PULSE:    if (cnt_q == PW_LAST) state_d = RECHARGE;
            RECHARGE: if (cnt_q == RW_LAST) state_d = BLANK;
            BLANK: begin
                if (cnt_q == BW_LAST) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new request re-sets a bit cleared by the grant on the same edge.
    always_comb begin
        pending_d = pending_q;
        if (grant) begin
            pending_d = pending_d & ~chan_onehot(win_chan);
        end
        pending_d = pending_d | (req_vec & ~svc_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= CH_A;
            pending_q <= '0;
            done_q    <= '0;
            overrun_q <= 1'b0;
            fault_q   <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
            if (grant) begin
                sel_q <= win_chan;
            end
            pending_q <= pending_d;
            done_q    <= finish ? chan_onehot(sel_q) : 3'b000;
            overrun_q <= |(req_vec & svc_mask);
            fault_q   <= timeout;
            if (timeout) begin
                sticky_q <= 1'b1;
            end
        end
    end

    assign pace_en      = (state_q == PULSE);
    assign recharge_en  = (state_q == RECHARGE);
    assign blank        = (state_q == PULSE) || (state_q == RECHARGE) || (state_q == BLANK);
    assign busy         = (state_q != IDLE);
    assign pace_sel     = sel_q;
    assign pending      = pending_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign charge_fault = fault_q;
    assign fault_sticky = sticky_q;

endmodule

// File: tb/tb_pace_output_scheduler.sv
// Randomized and directed stimulus for pace_output_scheduler, checked every
// cycle against a service-timeline reference model.
module tb_pace_output_scheduler;

    localparam int PW = 4;
    localparam int RW = 6;
    localparam int BW = 10;
    localparam int CT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_rv = 1'b0, req_lv = 1'b0;
    logic       charge_ready = 1'b1;
    logic       pace_en, recharge_en, blank, busy, overrun, charge_fault, fault_sticky;
    logic [1:0] pace_sel;
    logic [2:0] pending, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pace_output_scheduler #(
        .CNT_W          (32),
        .PULSE_WIDTH    (PW),
        .RECHARGE_WIDTH (RW),
        .BLANK_WIDTH    (BW),
        .CHARGE_TIMEOUT (CT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_a        (req_a),
        .req_rv       (req_rv),
        .req_lv       (req_lv),
        .charge_ready (charge_ready),
        .pace_en      (pace_en),
        .recharge_en  (recharge_en),
        .pace_sel     (pace_sel),
        .blank        (blank),
        .busy         (busy),
        .pending      (pending),
        .done         (done),
        .overrun      (overrun),
        .charge_fault (charge_fault),
        .fault_sticky (fault_sticky)
    );

    // Reference model: a service is a timeline measured in cycles since the
    // grant (el). ps is the el of the first pulse cycle, -1 while charging.
    logic [2:0] m_pend   = '0;
    logic [2:0] m_done   = '0;
    bit         m_busy   = 0;
    bit         m_ovr    = 0;
    bit         m_cf     = 0;
    bit         m_sticky = 0;
    int         m_ch     = 0;
    int         m_el     = 0;
    int         m_ps     = -1;

    always @(posedge clk) begin
        logic [2:0] reqv, np;
        bit         was_busy;
        int         was_ch;
        reqv   = {req_lv, req_rv, req_a};
        m_done = '0;
        m_ovr  = 0;
        m_cf   = 0;
        if (rst) begin
            m_pend = '0; m_busy = 0; m_ch = 0; m_el = 0; m_ps = -1; m_sticky = 0;
        end else begin
            was_busy = m_busy;
            was_ch   = m_ch;
            np       = m_pend;
            if (!m_busy) begin
                if (m_pend != 0) begin
                    if (m_pend[1])      m_ch = 1;
                    else if (m_pend[2]) m_ch = 2;
                    else                m_ch = 0;
                    np[m_ch] = 1'b0;
                    m_busy = 1; m_el = 0; m_ps = -1;
                end
            end else begin
                if (m_ps < 0) begin
                    if (charge_ready) m_ps = m_el + 1;
                    else if (m_el == CT - 1) begin
                        m_busy = 0; m_cf = 1; m_sticky = 1;
                    end
                end
                if (m_busy && m_ps >= 0 && m_el == m_ps + PW + RW + BW - 1) begin
                    m_busy = 0;
                    m_done[m_ch] = 1'b1;
                end
                m_el++;
            end
            for (int i = 0; i < 3; i++) begin
                if (reqv[i]) begin
                    if (was_busy && was_ch == i) m_ovr = 1;
                    else np[i] = 1'b1;
                end
            end
            m_pend = np;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit charged, e_pace, e_rech, e_blank;
        charged = m_busy && m_ps >= 0 && m_el >= m_ps;
        e_pace  = charged && m_el < m_ps + PW;
        e_rech  = charged && m_el >= m_ps + PW && m_el < m_ps + PW + RW;
        e_blank = charged;
        check_eq("pace_en",      32'(pace_en),      32'(e_pace));
        check_eq("recharge_en",  32'(recharge_en),  32'(e_rech));
        check_eq("blank",        32'(blank),        32'(e_blank));
        check_eq("busy",         32'(busy),         32'(m_busy));
        check_eq("pace_sel",     32'(pace_sel),     32'(m_ch));
        check_eq("pending",      32'(pending),      32'(m_pend));
        check_eq("done",         32'(done),         32'(m_done));
        check_eq("overrun",      32'(overrun),      32'(m_ovr));
        check_eq("charge_fault", 32'(charge_fault), 32'(m_cf));
        check_eq("fault_sticky", 32'(fault_sticky), 32'(m_sticky));
    endtask

    // Check the state after the previous edge, then drive inputs for the next.
    task automatic cycle(input logic [2:0] r, input logic rdy, input logic rs);
        @(negedge clk);
        check_outputs();
        req_a        = r[0];
        req_rv       = r[1];
        req_lv       = r[2];
        charge_ready = rdy;
        rst          = rs;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(3'b000, rdy, 1'b0);
    endtask

    initial begin
        bit rdy;
        cycle(3'b000, 1'b1, 1'b1);
        cycle(3'b000, 1'b1, 1'b1);
        cycle(3'b000, 1'b1, 1'b0);
        idle(2, 1'b1);

        // single RV service
        cycle(3'b010, 1'b1, 1'b0);
        idle(30, 1'b1);

        // three simultaneous requests: RV, LV, A
        cycle(3'b111, 1'b1, 1'b0);
        idle(75, 1'b1);

        // repeat RV during its pulse (overrun) plus A in the same window
        cycle(3'b010, 1'b1, 1'b0);
        idle(3, 1'b1);
        cycle(3'b011, 1'b1, 1'b0);
        idle(55, 1'b1);

        // charge timeout on LV, then a normal LV service
        cycle(3'b100, 1'b0, 1'b0);
        idle(12, 1'b0);
        cycle(3'b100, 1'b1, 1'b0);
        idle(28, 1'b1);

        // charge_ready arriving late in CHARGE
        cycle(3'b001, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(28, 1'b1);

        // reset during RECHARGE with A and LV pending
        cycle(3'b010, 1'b1, 1'b0);
        idle(7, 1'b1);
        cycle(3'b101, 1'b1, 1'b0);
        cycle(3'b000, 1'b1, 1'b1);
        idle(20, 1'b1);

        // randomized traffic
        rdy = 1;
        for (int i = 0; i < 2500; i++) begin
            logic [2:0] r;
            for (int b = 0; b < 3; b++) r[b] = ($urandom_range(0, 39) == 0);
            if (rdy) rdy = ($urandom_range(0, 29) != 0);
            else     rdy = ($urandom_range(0, 5) == 0);
            cycle(r, rdy, $urandom_range(0, 799) == 0);
        end
        idle(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pace_output_scheduler.md
Name: pace_output_scheduler

Overview:
- Shares the single pacing output stage (HV capacitor plus switch matrix) between the three pacing requesters: atrium, right ventricle and left ventricle.
- Per granted request it sequences four phases: capacitor-ready wait, pulse, active recharge, post-pace blanking.
- Blanking is driven to the sensing block so it ignores pacing artifacts.
- Sits between the pacemaker timing FSM (requester) and the pacing block (output stage).

Parameters:
- CNT_W, 32, width of the shared phase counter.
- PULSE_WIDTH, 100_000, cycles pace_en is high (1 ms at 100 MHz); must be ≥1.
- RECHARGE_WIDTH, 300_000, cycles recharge_en is high (3 ms); must be ≥1.
- BLANK_WIDTH, 2_500_000, post-recharge blanking cycles (25 ms); must be ≥1.
- CHARGE_TIMEOUT, 1_000_000, maximum cycles spent waiting for charge_ready (10 ms); must be ≥1.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous reset, active-high.
- req_a  in  1  atrial pace request, one-cycle pulse or level; sampled every edge.
- req_rv  in  1  right-ventricle pace request.
- req_lv  in  1  left-ventricle pace request.
- charge_ready  in  1  output capacitor charged, from the pacing block.
- pace_en  out  1  output switch enable (pulse phase).
- recharge_en  out  1  active recharge switch enable.
- pace_sel  out  2  channel routed to the output: 0=A, 1=RV, 2=LV; 3 is never driven.
- blank  out  1  sense blanking, all chambers.
- busy  out  1  state != IDLE.
- pending  out  3  latched requests {lv, rv, a}.
- done  out  3  one-cycle completion strobe per channel {lv, rv, a}.
- overrun  out  1  one-cycle strobe: request ignored because its channel is in service.
- charge_fault  out  1  one-cycle strobe: charge timeout.
- fault_sticky  out  1  set by any charge timeout; cleared only by rst.

Behaviour:
- Reset (synchronous, takes effect at the edge where rst=1, regardless of state):
  - state=IDLE, counter=0, pending=0.
  - All outputs low: pace_sel=0, fault_sticky=0.
  - Reset mid-pulse drops pace_en after that edge; no done strobe is issued.
- Request latching:
  - pending[i] sets on any edge where req_i=1, unless channel i is in service (state != IDLE and pace_sel==i). In that case the request is dropped and overrun pulses the next cycle.
  - A request for a channel that is already pending coalesces into it (no counting).
- States, with outputs decoded from the registered state and the counter cleared on every state entry:
  - IDLE: if pending != 0, pick the winner by fixed priority RV > LV > A, load pace_sel, clear that pending bit at the same edge, and go to CHARGE. Only pending bits registered before this edge are eligible; a same-edge req waits one cycle.
  - CHARGE: if charge_ready, go to PULSE. Otherwise, when the counter reaches CHARGE_TIMEOUT-1, go to IDLE, pulse charge_fault and set fault_sticky. The request is discarded and no done strobe is issued.
  - PULSE: pace_en=1 and blank=1. Go to RECHARGE when the counter reaches PULSE_WIDTH-1, giving exactly PULSE_WIDTH cycles.
  - RECHARGE: recharge_en=1 and blank=1, for exactly RECHARGE_WIDTH cycles.
  - BLANK: blank=1 for exactly BLANK_WIDTH cycles, then go to IDLE. done[pace_sel] pulses for the first IDLE cycle.
- pace_en and recharge_en are never high together, and never both high across any cycle boundary (no gap cycle required, because both are decoded from state).
- pace_sel is held constant from leaving IDLE until re-entry to IDLE.
- Latency, with charge_ready steady high:
  - req high at edge E → pending visible after E.
  - CHARGE after E+1.
  - pace_en high after E+2.
  - Total service time is 1 + PULSE_WIDTH + RECHARGE_WIDTH + BLANK_WIDTH cycles after leaving IDLE.
- Back-to-back service: the next pending channel leaves IDLE at the edge after the done-strobe cycle begins, so each service spends exactly one cycle in IDLE.
- charge_ready dropping during PULSE/RECHARGE/BLANK is ignored.
- Counter arithmetic is unsigned CNT_W bits. Comparisons are equality with WIDTH-1, so the counter never wraps.

Decomposition:
- Shared package pace_pkg holds:
  - the state enum (IDLE, CHARGE, PULSE, RECHARGE, BLANK);
  - channel codes CH_A=2'd0, CH_RV=2'd1, CH_LV=2'd2;
  - default timing constants, shared with the pacemaker timing FSM.
- One natural sub-module: pace_prio_sel, a combinational fixed-priority picker (3-bit pending → valid + 2-bit channel). Everything else stays in the top module.

Test Plan (PULSE_WIDTH=4, RECHARGE_WIDTH=6, BLANK_WIDTH=10, CHARGE_TIMEOUT=8, charge_ready=1 unless stated):
- Single req_rv pulse at edge E → pace_sel=1; pace_en high edges E+2..E+5 (4 cycles); recharge_en 6 cycles; blank 20 cycles; done[1] one cycle after blank falls; busy low afterwards.
- req_a, req_rv, req_lv together in IDLE → service order RV, LV, A; pending goes 111 → 101 → 001 → 000; exactly one IDLE cycle between services; three done strobes.
- req_rv again during RV PULSE → overrun pulses once, no second RV service; req_a during the same window → A served next.
- charge_ready=0 with req_lv → 8 cycles in CHARGE, then charge_fault pulse, fault_sticky=1, no pace_en, no done; a later req_lv with ready=1 is served normally and fault_sticky stays 1.
- charge_ready raised 3 cycles into CHARGE → pace_en rises the cycle after ready is sampled; no fault.
- rst asserted during RECHARGE with pending=101 → after that edge all outputs 0, pending=0, state IDLE, no done; no pacing until a new request.
